soc_system_sysid_reader: RTL
============================

# soc_system_sysid_reader

Avalon-MM master that reads the two words of the system-ID slave (address 0: system ID, address 1: build timestamp) and compares them against expected values. It runs once per `start` pulse and reports captured values, per-word match flags, an overall pass flag and a timeout error. It sits on the same Avalon fabric as the ID slave and is used by boot/self-test logic to confirm that the FPGA image matches the software build.

## Interface
Parameters:
- `EXPECTED_ID`, 32'd4368 (0x0000_1110): required word at address 0.
- `EXPECTED_TIMESTAMP`, 32'd1546432878 (0x5C2C_B16E): required word at address 1.
- `TIMEOUT_CYCLES`, 255: maximum cycles allowed per read transaction (command phase plus data phase); range 1..65535.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: **reset is synchronous and active-low**.
- `start` in 1: one-cycle request; sampled only in IDLE, ignored otherwise.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is left.
- `done` out 1: one-cycle pulse in DONE.
- `pass` out 1: `id_ok & ts_ok & ~timeout`; valid from `done`, held until next `start`.
- `id_ok`, `ts_ok` out 1: per-word compare results; held.
- `timeout` out 1: a transaction exceeded `TIMEOUT_CYCLES`; held.
- `id_value`, `ts_value` out 32: captured readdata; held.
- `avm_address` out 1: word address (0 = ID, 1 = timestamp).
- `avm_read` out 1: read command.
- `avm_waitrequest` in 1: slave stall; the command is accepted on a cycle where `avm_read & ~avm_waitrequest`.
- `avm_readdata` in 32: read data.
- `avm_readdatavalid` in 1: qualifies `avm_readdata`.

## Operation
- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- IDLE: `start` -> RD_ID. Clear the match, pass and timeout flags; do not clear `id_value`/`ts_value`.
- RD_ID / RD_TS: `avm_read`=1, with `avm_address` 0 or 1 respectively. Hold both outputs stable while `avm_waitrequest`=1. On acceptance, go to WAIT_*. If `avm_readdatavalid` is high in the acceptance cycle (zero latency), capture immediately and skip WAIT_*.
- WAIT_*: `avm_read`=0. On `avm_readdatavalid`, capture `avm_readdata` and set the compare flag (`==` over the full 32 bits). Then WAIT_ID -> RD_TS and WAIT_TS -> DONE.
- Timeout: a counter is cleared on entry to each RD_* state and increments in every RD_*/WAIT_* cycle. When it reaches `TIMEOUT_CYCLES` without data:
  - set `timeout`=1;
  - drop `avm_read`;
  - go to DONE, with the remaining read not issued and its flag left 0.
- Data arriving in the same cycle the counter reaches the limit counts as data, not timeout.
- `avm_readdatavalid` outside WAIT_*/RD_* acceptance (e.g. a late response after a timeout) is ignored.
- DONE: `done`=1 for one cycle -> IDLE.
- Reset (any cycle, including mid-transaction): state IDLE. All outputs 0, including `avm_read`, `avm_address`, `busy`, `done`, flags and captured values. An outstanding read is abandoned; its late `readdatavalid` is ignored.

## Timing
- Zero waitrequest, read latency 1:
  - `start` sampled cycle 0;
  - `avm_read`/addr 0 in cycle 1;
  - capture in cycle 2;
  - `avm_read`/addr 1 in cycle 3;
  - capture in cycle 4;
  - `done` in cycle 5.
- Each waitrequest cycle or extra latency cycle adds one cycle.
- With zero latency, `done` occurs in cycle 3.
- Flag and value outputs are registered; they update in the cycle after capture.
- `start` asserted while `busy` has no effect. `start` in the DONE cycle is also ignored.

## Structure
- Package `soc_system_sysid_pkg`:
  - state enum;
  - default `EXPECTED_ID` and `EXPECTED_TIMESTAMP` constants;
  - `SYSID_ADDR_ID`=0 and `SYSID_ADDR_TS`=1.
- Single module with no sub-module. The timeout counter is inline, `$clog2(TIMEOUT_CYCLES+1)` bits wide.

## Test plan
- Slave model returns 4368 / 1546432878, waitrequest=0, latency 1, `start` at cycle 0 -> `done` at cycle 5 with `pass`=1, `id_ok`=1, `ts_ok`=1, `avm_address` sequence 0 then 1.
- Timestamp returns 0x5C2C_B16F -> `id_ok`=1, `ts_ok`=0, `pass`=0, `ts_value`=0x5C2C_B16F.
- Waitrequest high for 3 cycles on each read, latency 2 -> address and read stable while stalled; `done` at cycle 13; `pass`=1.
- `TIMEOUT_CYCLES`=8 and the slave never asserts readdatavalid for address 0 -> `timeout`=1 and `done` 8 cycles after the first `avm_read`; no address-1 read; `pass`=0. A late readdatavalid is ignored.
- `reset_n` low during WAIT_TS -> next cycle all outputs 0 in IDLE. A subsequent `start` runs a full clean pass.
- Zero-latency slave (readdatavalid coincident with acceptance) -> `done` at cycle 3, `pass`=1. A `start` pulse while busy is ignored.

Source files
------------

// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the system-ID reader.
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdId,
    StWaitId,
    StRdTs,
    StWaitTs,
    StDone
  } sysid_state_e;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd4368;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1546432878;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/soc_system_sysid_reader.sv
// Avalon-MM master that reads the system-ID and timestamp words once per start
// and compares them against the expected build values.
module soc_system_sysid_reader
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter value in the last cycle a transaction may still complete.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  sysid_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] id_value_q, id_value_d, ts_value_q, ts_value_d;
  logic id_ok_q, id_ok_d, ts_ok_q, ts_ok_d, timeout_q, timeout_d;

  logic in_rd, in_wait, accepted, got_data, expired;

  assign in_rd    = (state_q == StRdId) || (state_q == StRdTs);
  assign in_wait  = (state_q == StWaitId) || (state_q == StWaitTs);
  assign accepted = in_rd && !avm_waitrequest;
  // Zero-latency data is only honoured in the acceptance cycle itself.
  assign got_data = (in_wait || accepted) && avm_readdatavalid;
  assign expired  = (in_rd || in_wait) && (cnt_q == CntLast) && !got_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;

    if (in_rd || in_wait) begin
      cnt_d = cnt_q + CntW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRdId;
          cnt_d     = '0;
          id_ok_d   = 1'b0;
          ts_ok_d   = 1'b0;
          timeout_d = 1'b0;
        end
      end
      StRdId, StWaitId: begin
        if (got_data) begin
          id_value_d = avm_readdata;
          id_ok_d    = (avm_readdata == EXPECTED_ID);
          state_d    = StRdTs;
          cnt_d      = '0;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (accepted) begin
          state_d = StWaitId;
        end
      end
      StRdTs, StWaitTs: begin
        if (got_data) begin
          ts_value_d = avm_readdata;
          ts_ok_d    = (avm_readdata == EXPECTED_TIMESTAMP);
          state_d    = StDone;
        end else if (expired) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (accepted) begin
          state_d = StWaitTs;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      id_value_q <= '0;
      ts_value_q <= '0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign avm_read    = in_rd;
  assign avm_address = (state_q == StRdTs) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout     = timeout_q;
  assign pass        = id_ok_q && ts_ok_q && !timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule
